multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle sequencer for the MIPS datapath. It replaces the single-cycle ControlUnit decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It supports the same opcode set: R-format, J, JAL, BEQ, ADDI, SUBI, LW and SW. It also inserts wait states on a shared instruction/data memory through a ready handshake, and it parks on an illegal opcode.

## Interface
- No parameters.
- Clk  in  1  single clock; all state updates on its rising edge.
- Rst_n  in  1  reset; asynchronous and active-low.
- Opcode  in  6  instruction [31:26] taken from the instruction register; sampled only in DECODE.
- MemReady  in  1  memory completion for the current MemRead/MemWrite cycle.
- PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, ALUSrcA, RegWrite  out  1 each  datapath strobes and selects.
- RegDst  out  2  register destination select: 00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  register write-data select: 00 ALUOut, 01 MDR, 10 PC.
- ALUSrcB  out  2  ALU B operand select: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- ALUOp  out  2  ALU operation class: 00 add, 01 sub, 10 funct.
- PCSource  out  2  PC source select: 00 ALU, 01 ALUOut, 10 jump target.
- InstrDone  out  1  one-cycle pulse in the final cycle of each instruction.
- Illegal  out  1  high while parked in HALT.
- State  out  4  current state encoding, for debug and bench use.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, SUBIEX=11, IWB=12, JAL=13, HALT=14. Code 15 is unreachable and recovers to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal MemReady; this is the only Mealy qualification in the block.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 001000 → ADDIEX
  - 001010 → SUBIEX
  - any other value → HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for LW, MEMWR for SW; the opcode is re-read here because the IR holds it stable.
- MEMRD: MemRead=1, IorD=1. Hold while MemReady=0, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01, InstrDone=1, then FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold while MemReady=0. InstrDone=MemReady; go to FETCH on MemReady=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RWB.
- RWB: RegWrite=1, RegDst=01, MemtoReg=00, InstrDone=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1, then FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1, then FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10, InstrDone=1, then FETCH. The PC already holds PC+4 from FETCH, so $31 receives the return address.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then IWB.
- SUBIEX: same as ADDIEX except ALUOp=01, then IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00, InstrDone=1, then FETCH.
- HALT: Illegal=1, all other outputs 0. Absorbing; only Rst_n exits it.

## Timing
- Rst_n=0 forces State=FETCH asynchronously and forces every output to 0 while asserted, including the FETCH-decoded MemRead.
- The first FETCH cycle is the first rising edge after Rst_n deasserts.
- Reset asserted mid-instruction aborts the instruction immediately: no further strobes are issued and no InstrDone pulse occurs.
- Cycle counts with MemReady held at 1:
  - 3 cycles: BEQ, J, JAL.
  - 4 cycles: R-format, SW, ADDI, SUBI.
  - 5 cycles: LW.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Outputs are decoded from the registered state, so they are glitch-free apart from the MemReady-qualified terms in FETCH and MEMWR.
- Opcode is ignored outside DECODE and MEMADR.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- InstrDone is never high in two consecutive cycles.

## Test plan
- R-format: Rst_n low then released, MemReady=1, Opcode=000000 → State 0,1,6,7,0; RWB has RegWrite=1, RegDst=01; InstrDone pulses on cycle 4.
- LW with wait states: Opcode=100011, MemReady=0 for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total; IRWrite and PCWrite high only on the FETCH cycle where MemReady=1; MEMWB has MemtoReg=01.
- SW, BEQ, J in sequence: Opcode=101011, then 000100, then 000010 → lengths 4, 3, 3; MemWrite=1 in MEMWR; PCWriteCond=1 with PCSource=01 in BRANCH; PCWrite=1 with PCSource=10 in JUMP.
- JAL, ADDI, SUBI: JAL state has RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1; ADDIEX has ALUOp=00 with ALUSrcB=10; SUBIEX has ALUOp=01 with ALUSrcB=10; IWB has RegDst=00 for both.
- Illegal opcode: Opcode=111111 in DECODE → State=14 and Illegal=1, held for 50 cycles regardless of inputs; Rst_n pulse → State=0 and Illegal=0.
- Asynchronous reset in MEMRD: drop Rst_n between clock edges → outputs go to 0 within the same cycle; after release, the first fetch has MemRead=1, IorD=0, and no InstrDone pulse was emitted for the aborted LW.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer stepping MIPS instructions through fetch, decode, execute, memory and writeback
module multicycle_control_fsm (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB,
    BRANCH, JUMP, ADDIEX, SUBIEX, IWB, JAL, HALT, BAD
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SUBI = 6'h0a, OP_LW = 6'h23, OP_SW = 6'h2b;
  state_t state, nxt;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= FETCH;
    else state <= nxt;
  // Outputs are gated by Rst_n so the FETCH decode stays silent while reset is held
  always_comb begin
    nxt = FETCH;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    IRWrite = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    ALUSrcA = 1'b0;
    RegWrite = 1'b0;
    RegDst = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    PCSource = 2'b00;
    InstrDone = 1'b0;
    Illegal = 1'b0;
    if (Rst_n)
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
          nxt = MemReady ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          nxt = Opcode == OP_R ? EXEC :
                (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                Opcode == OP_BEQ ? BRANCH :
                Opcode == OP_J ? JUMP :
                Opcode == OP_JAL ? JAL :
                Opcode == OP_ADDI ? ADDIEX :
                Opcode == OP_SUBI ? SUBIEX : HALT;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt = Opcode == OP_LW ? MEMRD : MEMWR;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD = 1'b1;
          nxt = MemReady ? MEMWB : MEMRD;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
          InstrDone = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD = 1'b1;
          InstrDone = MemReady;
          nxt = MemReady ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp = 2'b10;
          nxt = RWB;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst = 2'b01;
          InstrDone = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp = 2'b01;
          PCWriteCond = 1'b1;
          PCSource = 2'b01;
          InstrDone = 1'b1;
        end
        JUMP: begin
          PCWrite = 1'b1;
          PCSource = 2'b10;
          InstrDone = 1'b1;
        end
        JAL: begin
          PCWrite = 1'b1;
          PCSource = 2'b10;
          RegWrite = 1'b1;
          RegDst = 2'b10;
          MemtoReg = 2'b10;
          InstrDone = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt = IWB;
        end
        SUBIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp = 2'b01;
          nxt = IWB;
        end
        IWB: begin
          RegWrite = 1'b1;
          InstrDone = 1'b1;
        end
        HALT: begin
          Illegal = 1'b1;
          nxt = HALT;
        end
        default: nxt = FETCH;
      endcase
  end
  assign State = state;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: vector table, directed corner cases and randomized instruction streams
module tb_multicycle_control_fsm;
  logic Clk = 1'b0, Rst_n = 1'b0, MemReady = 1'b0;
  logic [5:0] Opcode = 6'h00;
  logic PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, ALUSrcA, RegWrite, InstrDone, Illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, irw, mrd, mwr, asa, rw;
    logic [1:0] rd, m2r, asb, aop, pcs;
    logic done, ill;
  } snap_t;
  typedef struct {
    logic [5:0] op;
    int len;
    logic [19:0] trace;
  } vec_t;
  snap_t cur;
  snap_t tr[$];
  int st_q[$];
  int rdy_q[$];
  int tests = 0, fails = 0;
  multicycle_control_fsm dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .InstrDone(InstrDone), .Illegal(Illegal), .State(State)
  );
  assign cur = {State, PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, ALUSrcA, RegWrite,
                RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal};
  always #5 Clk = ~Clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0a, 6'h23, 6'h2b};
  endfunction
  task automatic add(input int s, input int r);
    st_q.push_back(s);
    rdy_q.push_back(r);
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic do_reset;
    Rst_n = 1'b0;
    MemReady = 1'b1;
    Opcode = 6'h00;
    @(negedge Clk);
    chk("reset outputs", 32'(cur), 0);
    tick;
    Rst_n = 1'b1;
  endtask
  // Expected trace: MemReady=2 marks cycles where the handshake is ignored and is driven randomly
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit lgl = is_legal(op);
    int n_mrd = 0, n_mwr = 0, n_rw = 0, n_irw = 0, n_pcw = 0, n_pcwc = 0;
    tr.delete();
    st_q.delete();
    rdy_q.delete();
    for (int i = 0; i <= fw; i++) add(0, int'(i == fw));
    add(1, 2);
    case (op)
      6'h00: begin add(6, 2); add(7, 2); end
      6'h23: begin add(2, 2); for (int i = 0; i <= mw; i++) add(3, int'(i == mw)); add(4, 2); end
      6'h2b: begin add(2, 2); for (int i = 0; i <= mw; i++) add(5, int'(i == mw)); end
      6'h04: add(8, 2);
      6'h02: add(9, 2);
      6'h03: add(13, 2);
      6'h08: begin add(10, 2); add(12, 2); end
      6'h0a: begin add(11, 2); add(12, 2); end
      default: add(14, 2);
    endcase
    foreach (st_q[i]) begin
      MemReady = rdy_q[i] == 2 ? 1'($urandom) : 1'(rdy_q[i]);
      Opcode = (st_q[i] == 1 || st_q[i] == 2) ? op : 6'($urandom);
      @(negedge Clk);
      tr.push_back(cur);
      chk($sformatf("state op%h cyc%0d", op, i), State, st_q[i]);
      chk($sformatf("done op%h cyc%0d", op, i), InstrDone, lgl && i == st_q.size() - 1);
      n_mrd += MemRead;
      n_mwr += MemWrite;
      n_rw += RegWrite;
      n_irw += IRWrite;
      n_pcw += PCWrite;
      n_pcwc += PCWriteCond;
      tick;
    end
    chk($sformatf("memread count op%h", op), n_mrd, fw + 1 + (op == 6'h23 ? mw + 1 : 0));
    chk($sformatf("memwrite count op%h", op), n_mwr, op == 6'h2b ? mw + 1 : 0);
    chk($sformatf("regwrite count op%h", op), n_rw, op inside {6'h00, 6'h23, 6'h03, 6'h08, 6'h0a});
    chk($sformatf("irwrite count op%h", op), n_irw, 1);
    chk($sformatf("pcwrite count op%h", op), n_pcw, 1 + (op == 6'h02 || op == 6'h03));
    chk($sformatf("pcwritecond count op%h", op), n_pcwc, op == 6'h04);
  endtask
  initial begin
    vec_t tbl[8];
    logic [5:0] ops[8];
    int bad;
    tbl = '{'{6'h00, 4, 20'h07610}, '{6'h23, 5, 20'h43210}, '{6'h2b, 4, 20'h05210},
            '{6'h04, 3, 20'h00810}, '{6'h02, 3, 20'h00910}, '{6'h03, 3, 20'h00d10},
            '{6'h08, 4, 20'h0ca10}, '{6'h0a, 4, 20'h0cb10}};
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0a};
    do_reset;
    foreach (tbl[k]) begin
      vec_t v = tbl[k];
      for (int i = 0; i < v.len; i++) begin
        MemReady = 1'b1;
        Opcode = v.op;
        @(negedge Clk);
        chk($sformatf("table op%h cyc%0d state", v.op, i), State, v.trace[4*i +: 4]);
        chk($sformatf("table op%h cyc%0d done", v.op, i), InstrDone, i == v.len - 1);
        tick;
      end
    end
    run_instr(6'h00, 0, 0);
    chk("rwb regwrite", tr[3].rw, 1);
    chk("rwb regdst", tr[3].rd, 2'b01);
    run_instr(6'h23, 2, 3);
    chk("lw wait length", tr.size(), 10);
    foreach (tr[i]) begin
      chk($sformatf("lw irwrite cyc%0d", i), tr[i].irw, i == 2);
      chk($sformatf("lw pcwrite cyc%0d", i), tr[i].pcw, i == 2);
    end
    chk("memwb memtoreg", tr[9].m2r, 2'b01);
    run_instr(6'h2b, 0, 0);
    chk("sw length", tr.size(), 4);
    chk("memwr memwrite", tr[3].mwr, 1);
    run_instr(6'h04, 0, 0);
    chk("beq length", tr.size(), 3);
    chk("branch pcwritecond", tr[2].pcwc, 1);
    chk("branch pcsource", tr[2].pcs, 2'b01);
    run_instr(6'h02, 0, 0);
    chk("j length", tr.size(), 3);
    chk("jump pcwrite", tr[2].pcw, 1);
    chk("jump pcsource", tr[2].pcs, 2'b10);
    run_instr(6'h03, 0, 0);
    chk("jal fields", {tr[2].rd, tr[2].m2r, tr[2].rw, tr[2].pcw}, 6'b10_10_1_1);
    run_instr(6'h08, 0, 0);
    chk("addiex aop asb", {tr[2].aop, tr[2].asb}, 4'b00_10);
    chk("addi iwb regdst", tr[3].rd, 2'b00);
    run_instr(6'h0a, 0, 0);
    chk("subiex aop asb", {tr[2].aop, tr[2].asb}, 4'b01_10);
    chk("subi iwb regdst", tr[3].rd, 2'b00);
    run_instr(6'h3f, 0, 0);
    chk("halt illegal", tr[2].ill, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      MemReady = 1'($urandom);
      Opcode = 6'($urandom);
      @(negedge Clk);
      if (cur !== {4'd14, 19'd0, 1'b1}) bad++;
      tick;
    end
    chk("halt held 50 cycles", bad, 0);
    Rst_n = 1'b0;
    #2;
    chk("halt async reset", 32'(cur), 0);
    tick;
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MemReady = i == 0 || i == 3 ? 1'b1 : 1'b0;
      Opcode = 6'h23;
      @(negedge Clk);
      if (i < 3) tick;
    end
    chk("abort lw in memrd", {State, MemRead, IorD}, {4'd3, 2'b11});
    #2;
    Rst_n = 1'b0;
    #1;
    chk("abort outputs cleared", 32'(cur), 0);
    @(negedge Clk);
    chk("abort no done", 32'(cur), 0);
    tick;
    Rst_n = 1'b1;
    MemReady = 1'b0;
    @(negedge Clk);
    chk("refetch after abort", {State, MemRead, IorD, InstrDone}, {4'd0, 3'b100});
    tick;
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0)
        do op = 6'($urandom); while (is_legal(op));
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      if (!is_legal(op)) do_reset;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
